load_queue_nway: RTL and testbench

Parametrised load queue for the out-of-order core's LSQ. It allocates loads in program order from N decode lanes and records load addresses from the execute stage. Every executing store's address is checked against younger, already-executed loads, and the oldest violating load is reported to the ROB for replay; loads are freed on in-order retirement. It replaces the fixed 2-wide queue and adds exact occupancy counting, wrap-phase pointers and oldest-violator selection.

---
 rtl/load_queue_nway_pkg.sv | 22 ++
 rtl/load_queue_nway_if.sv | 45 ++++
 rtl/load_queue_nway_oldest_select.sv | 33 +++
 rtl/load_queue_nway.sv | 177 +++++++++++++++++
 tb/tb_load_queue_nway.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_queue_nway_pkg.sv
// Shared helpers for the load queue.
//   lq_pw  : pointer width (entry index plus one wrap-phase bit) for a queue size
//   lq_age : distance of a pointer from a base pointer, modulo a power-of-2 span
// Entry records are built from the top module's parameters, so the entry
// struct is declared next to its storage in load_queue_nway.
package load_queue_nway_pkg;

    localparam int LQ_DEF_SIZE = 8;

    function automatic int lq_pw(input int size);
        return $clog2(size) + 1;
    endfunction

    // The span must be a power of 2; the subtraction wraps naturally and the
    // mask folds it into the span.
    function automatic logic [31:0] lq_age(input logic [31:0] ptr,
                                           input logic [31:0] base,
                                           input int unsigned span);
        return (ptr - base) & (span - 1);
    endfunction

endpackage

// File: rtl/load_queue_nway_if.sv
// Bus bundle between the LSQ control (master) and the load queue (slave).
// Carries dispatch (alloc_*), load-address writeback (ld_*), store-address
// checks (st_*), retirement, rollback, and the violation report (viol*).
interface load_queue_nway_if
    import load_queue_nway_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int ST_PORTS = 2,
    parameter int LQ_SIZE  = 8,
    parameter int XLEN     = 32,
    parameter int ROB_SIZE = 32
) ();
    localparam int RW = $clog2(ROB_SIZE);
    localparam int PW = lq_pw(LQ_SIZE);
    localparam int CW = $clog2(WIDTH + 1);

    logic                               rollback;
    logic [WIDTH-1:0]                   alloc_en;
    logic [WIDTH-1:0][XLEN-1:0]         alloc_pc;
    logic [WIDTH-1:0][RW-1:0]           alloc_robnum;
    logic [WIDTH-1:0][PW-1:0]           alloc_idx;
    logic [PW-1:0]                      free_slots;
    logic                               ld_en;
    logic [PW-1:0]                      ld_idx;
    logic [XLEN-1:0]                    ld_addr;
    logic [ST_PORTS-1:0]                st_en;
    logic [ST_PORTS-1:0][PW-1:0]        st_lqp;
    logic [ST_PORTS-1:0][XLEN-1:0]      st_addr;
    logic [CW-1:0]                      retire_cnt;
    logic                               viol;
    logic [RW-1:0]                      viol_robnum;
    logic [XLEN-1:0]                    viol_pc;

    modport master (
        output rollback, alloc_en, alloc_pc, alloc_robnum, ld_en, ld_idx, ld_addr,
               st_en, st_lqp, st_addr, retire_cnt,
        input  alloc_idx, free_slots, viol, viol_robnum, viol_pc
    );

    modport slave (
        input  rollback, alloc_en, alloc_pc, alloc_robnum, ld_en, ld_idx, ld_addr,
               st_en, st_lqp, st_addr, retire_cnt,
        output alloc_idx, free_slots, viol, viol_robnum, viol_pc
    );
endinterface

// File: rtl/load_queue_nway_oldest_select.sv
// lq_oldest_select: picks the oldest set bit of a per-entry match vector,
// where age is measured from the queue head and wraps around the array.
//   match  : one bit per entry
//   head   : head entry index (age 0)
//   onehot : single bit at the oldest matching entry (all zero if none)
//   idx    : index of that entry (0 if none)
module lq_oldest_select #(
    parameter int LQ_SIZE = 8,
    localparam int IW = $clog2(LQ_SIZE)
) (
    input  logic [LQ_SIZE-1:0] match,
    input  logic [IW-1:0]      head,
    output logic [LQ_SIZE-1:0] onehot,
    output logic [IW-1:0]      idx
);
    logic          found;
    logic [IW-1:0] e;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        e      = '0;
        for (int k = 0; k < LQ_SIZE; k++) begin
            e = head + IW'(k);
            if (!found && match[e]) begin
                found     = 1'b1;
                onehot[e] = 1'b1;
                idx       = e;
            end
        end
    end
endmodule

// File: rtl/load_queue_nway.sv
// load_queue_nway: N-wide load queue for the LSQ.
// Allocates loads in program order, records executed load addresses, checks
// every executing store against younger executed loads and reports the oldest
// violator (registered, one-cycle pulse); frees loads on in-order retirement.
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   lq (slave)     : see load_queue_nway_if
// Build option:
//   LQ_WORD_MATCH_EN : store/load addresses compared on [XLEN-1:2] only;
//                      undefined gives an exact full-width compare.
module load_queue_nway
    import load_queue_nway_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int ST_PORTS = 2,
    parameter int LQ_SIZE  = LQ_DEF_SIZE,
    parameter int XLEN     = 32,
    parameter int ROB_SIZE = 32
) (
    input logic              clock,
    input logic              reset_n,
    load_queue_nway_if.slave lq
);
    localparam int IW      = $clog2(LQ_SIZE);
    localparam int PW      = lq_pw(LQ_SIZE);
    localparam int RW      = $clog2(ROB_SIZE);
    localparam int CW      = $clog2(WIDTH + 1);
    localparam int MAX_RET = (1 << CW) - 1;

    typedef struct packed {
        logic            valid;
        logic            addr_valid;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] pc;
        logic [RW-1:0]   robnum;
    } lq_entry_t;

    lq_entry_t                 entry_q [LQ_SIZE];
    logic [PW-1:0]             head_q, tail_q, free_q;
    logic                      viol_q;
    logic [RW-1:0]             viol_robnum_q;
    logic [XLEN-1:0]           viol_pc_q;

    logic [PW-1:0]             count, free_now, ret_req, ret_eff, alloc_lim;
    logic [PW-1:0]             alloc_run, n_alloc, head_next, tail_next, free_next;
    logic [WIDTH-1:0][PW-1:0]  alloc_ptr;
    logic [WIDTH-1:0]          accept;
    logic [IW-1:0]             ld_i;
    logic                      ld_ok;
    logic                      unused_ld_phase;
    logic [LQ_SIZE-1:0]        byp, st_match, sel_onehot;
    logic [IW-1:0]             sel_idx;
    logic                      sel_hit;

    function automatic logic addr_eq(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
`ifdef LQ_WORD_MATCH_EN
        return a[XLEN-1:2] == b[XLEN-1:2];
`else
        return a == b;
`endif
    endfunction

    // Pointer arithmetic: the extra phase bit lets head==tail mean empty and
    // count==LQ_SIZE mean full without a separate flag.
    assign count     = tail_q - head_q;
    assign free_now  = PW'(LQ_SIZE) - count;
    assign ret_req   = PW'(lq.retire_cnt);
    assign ret_eff   = (ret_req > count) ? count : ret_req;
    // Slots retired this cycle can be reused by this cycle's allocations.
    assign alloc_lim = free_now + ret_eff;

    always_comb begin
        alloc_run = tail_q;
        for (int i = 0; i < WIDTH; i++) begin
            alloc_ptr[i] = alloc_run;
            if (lq.alloc_en[i]) alloc_run = alloc_run + PW'(1);
        end
    end

    always_comb begin
        n_alloc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = lq.alloc_en[i] && ((alloc_ptr[i] - tail_q) < alloc_lim);
            n_alloc   = n_alloc + PW'(accept[i]);
        end
    end

    assign head_next = head_q + ret_eff;
    assign tail_next = tail_q + n_alloc;
    assign free_next = PW'(LQ_SIZE) - (tail_next - head_next);

    // Load writeback addresses an entry by index only; the phase bit is not
    // needed because a valid entry has exactly one live pointer.
    assign ld_i            = lq.ld_idx[IW-1:0];
    assign unused_ld_phase = lq.ld_idx[PW-1];
    assign ld_ok           = lq.ld_en && entry_q[ld_i].valid;

    always_comb begin
        for (int e = 0; e < LQ_SIZE; e++)
            byp[e] = ld_ok && (ld_i == IW'(e));
    end

    // A load matches a store when it is at or beyond the store's captured
    // position (younger) and has an address, either stored or arriving now.
    always_comb begin
        st_match = '0;
        for (int e = 0; e < LQ_SIZE; e++) begin
            for (int s = 0; s < ST_PORTS; s++) begin
                if (lq.st_en[s] && entry_q[e].valid && (entry_q[e].addr_valid || byp[e])
                    && (lq_age(32'(e), 32'(head_q[IW-1:0]), LQ_SIZE)
                        >= lq_age(32'(lq.st_lqp[s]), 32'(head_q), 2 * LQ_SIZE))
                    && addr_eq(byp[e] ? lq.ld_addr : entry_q[e].addr, lq.st_addr[s]))
                    st_match[e] = 1'b1;
            end
        end
    end

    lq_oldest_select #(.LQ_SIZE(LQ_SIZE)) u_oldest (
        .match  (st_match),
        .head   (head_q[IW-1:0]),
        .onehot (sel_onehot),
        .idx    (sel_idx)
    );

    assign sel_hit = |sel_onehot;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q        <= '0;
            tail_q        <= '0;
            free_q        <= PW'(LQ_SIZE);
            viol_q        <= 1'b0;
            viol_robnum_q <= '0;
            viol_pc_q     <= '0;
            for (int e = 0; e < LQ_SIZE; e++) entry_q[e] <= '0;
        end else if (lq.rollback) begin
            head_q        <= '0;
            tail_q        <= '0;
            free_q        <= PW'(LQ_SIZE);
            viol_q        <= 1'b0;
            viol_robnum_q <= '0;
            viol_pc_q     <= '0;
            for (int e = 0; e < LQ_SIZE; e++) entry_q[e] <= '0;
        end else begin
            head_q        <= head_next;
            tail_q        <= tail_next;
            free_q        <= free_next;
            viol_q        <= sel_hit;
            viol_robnum_q <= sel_hit ? entry_q[sel_idx].robnum : '0;
            viol_pc_q     <= sel_hit ? entry_q[sel_idx].pc : '0;

            if (ld_ok) begin
                entry_q[ld_i].addr       <= lq.ld_addr;
                entry_q[ld_i].addr_valid <= 1'b1;
            end
            // Retire clears come before allocation so a slot freed and
            // reallocated in the same cycle ends up holding the new load.
            for (int j = 0; j < MAX_RET; j++) begin
                if (PW'(j) < ret_eff)
                    entry_q[head_q[IW-1:0] + IW'(j)] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (accept[i])
                    entry_q[alloc_ptr[i][IW-1:0]] <= '{valid: 1'b1, addr_valid: 1'b0,
                                                       addr: '0, pc: lq.alloc_pc[i],
                                                       robnum: lq.alloc_robnum[i]};
            end
        end
    end

    assign lq.alloc_idx   = alloc_ptr;
    assign lq.free_slots  = free_q;
    assign lq.viol        = viol_q;
    assign lq.viol_robnum = viol_robnum_q;
    assign lq.viol_pc     = viol_pc_q;

endmodule

// File: tb/tb_load_queue_nway.sv
// Directed bench for load_queue_nway (WIDTH=2, ST_PORTS=2, LQ_SIZE=8).
// A vector table covers allocation, retirement, saturation and clamping;
// hand-written sequences cover violation detection, bypass, wrap, rollback
// and asynchronous reset.
module tb_load_queue_nway;
    localparam int WIDTH = 2, ST_PORTS = 2, LQ_SIZE = 8, XLEN = 32, ROB_SIZE = 32;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    load_queue_nway_if #(.WIDTH(WIDTH), .ST_PORTS(ST_PORTS), .LQ_SIZE(LQ_SIZE),
                         .XLEN(XLEN), .ROB_SIZE(ROB_SIZE)) lq_if ();

    load_queue_nway #(.WIDTH(WIDTH), .ST_PORTS(ST_PORTS), .LQ_SIZE(LQ_SIZE),
                      .XLEN(XLEN), .ROB_SIZE(ROB_SIZE)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .lq      (lq_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] alloc_en;
        logic [1:0] retire;
        logic [3:0] exp_idx0;
        logic [3:0] exp_idx1;
        logic [3:0] exp_free;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        lq_if.rollback     = 1'b0;
        lq_if.alloc_en     = '0;
        lq_if.alloc_pc     = '0;
        lq_if.alloc_robnum = '0;
        lq_if.ld_en        = 1'b0;
        lq_if.ld_idx       = '0;
        lq_if.ld_addr      = '0;
        lq_if.st_en        = '0;
        lq_if.st_lqp       = '0;
        lq_if.st_addr      = '0;
        lq_if.retire_cnt   = '0;
    endtask

    task automatic set_alloc(input logic [1:0] en, input int rob0, input int pc0);
        lq_if.alloc_en        = en;
        lq_if.alloc_robnum[0] = 5'(rob0);
        lq_if.alloc_robnum[1] = 5'(rob0 + 1);
        lq_if.alloc_pc[0]     = 32'(pc0);
        lq_if.alloc_pc[1]     = 32'(pc0 + 4);
    endtask

    task automatic store(input int port, input int lqp, input int addr);
        lq_if.st_en[port]   = 1'b1;
        lq_if.st_lqp[port]  = 4'(lqp);
        lq_if.st_addr[port] = 32'(addr);
    endtask

    task automatic ld(input int idx, input int addr);
        lq_if.ld_en   = 1'b1;
        lq_if.ld_idx  = 4'(idx);
        lq_if.ld_addr = 32'(addr);
    endtask

    task automatic expect_viol(input string name, input logic v, input int rob, input int pc);
        check({name, "_viol"}, 32'(lq_if.viol), 32'(v));
        check({name, "_rob"}, 32'(lq_if.viol_robnum), 32'(rob));
        check({name, "_pc"}, lq_if.viol_pc, 32'(pc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        //              alloc  ret  idx0   idx1   free
        vecs[0]  = '{2'b00, 2'd0, 4'd0,  4'd0,  4'd8};
        vecs[1]  = '{2'b11, 2'd0, 4'd0,  4'd1,  4'd6};
        vecs[2]  = '{2'b11, 2'd0, 4'd2,  4'd3,  4'd4};
        vecs[3]  = '{2'b11, 2'd0, 4'd4,  4'd5,  4'd2};
        vecs[4]  = '{2'b11, 2'd0, 4'd6,  4'd7,  4'd0};
        vecs[5]  = '{2'b11, 2'd2, 4'd8,  4'd9,  4'd0};  // full: retire frees room
        vecs[6]  = '{2'b01, 2'd0, 4'd10, 4'd11, 4'd0};  // full: load dropped
        vecs[7]  = '{2'b10, 2'd1, 4'd10, 4'd10, 4'd0};
        vecs[8]  = '{2'b00, 2'd2, 4'd11, 4'd11, 4'd2};
        vecs[9]  = '{2'b00, 2'd3, 4'd11, 4'd11, 4'd5};
        vecs[10] = '{2'b00, 2'd3, 4'd11, 4'd11, 4'd8};
        vecs[11] = '{2'b00, 2'd2, 4'd11, 4'd11, 4'd8};  // retire clamped on empty
        vecs[12] = '{2'b11, 2'd0, 4'd11, 4'd12, 4'd6};

        clr();
        reset_n = 1'b0;
        tick();
        tick();
        check("rst_free", 32'(lq_if.free_slots), 32'd8);
        expect_viol("rst", 1'b0, 0, 0);
        check("rst_idx1", 32'(lq_if.alloc_idx[1]), 32'd0);
        reset_n = 1'b1;

        for (int r = 0; r < 13; r++) begin
            clr();
            set_alloc(vecs[r].alloc_en, 2 * r, 32'h1000 + 8 * r);
            lq_if.retire_cnt = vecs[r].retire;
            #1;
            check($sformatf("vec%0d_idx0", r), 32'(lq_if.alloc_idx[0]), 32'(vecs[r].exp_idx0));
            check($sformatf("vec%0d_idx1", r), 32'(lq_if.alloc_idx[1]), 32'(vecs[r].exp_idx1));
            tick();
            check($sformatf("vec%0d_free", r), 32'(lq_if.free_slots), 32'(vecs[r].exp_free));
        end

        // Rollback outranks a same-cycle bypassed violation, alloc and retire.
        clr();
        lq_if.rollback   = 1'b1;
        set_alloc(2'b11, 30, 0);
        lq_if.retire_cnt = 2'd1;
        ld(11, 32'h700);
        store(0, 11, 32'h700);
        tick();
        clr();
        check("rb_free", 32'(lq_if.free_slots), 32'd8);
        expect_viol("rb", 1'b0, 0, 0);

        // Fill entries 0..7 with robnum 16+e, pc 0x2000+4e.
        for (int e = 0; e < 8; e += 2) begin
            clr();
            set_alloc(2'b11, 16 + e, 32'h2000 + 4 * e);
            #1;
            check($sformatf("fill%0d_idx0", e), 32'(lq_if.alloc_idx[0]), 32'(e));
            tick();
        end
        clr();
        check("fill_free", 32'(lq_if.free_slots), 32'd0);
        lq_if.retire_cnt = 2'd2;
        tick();
        clr();
        check("ret2_free", 32'(lq_if.free_slots), 32'd2);

        ld(2, 32'h100); tick();
        ld(5, 32'h100); tick();
        ld(6, 32'h300); tick();
        ld(4, 32'h400); tick();
        clr();
        check("ld_noviol", 32'(lq_if.viol), 32'd0);

        // Store at position 3: idx 5 is younger and flagged, idx 2 is older.
        store(0, 3, 32'h100);
        tick();
        clr();
        expect_viol("s1", 1'b1, 21, 32'h2014);
        tick();
        expect_viol("s1_pulse", 1'b0, 0, 0);

        // Two ports hit idx 6 and idx 4; idx 4 is older.
        store(0, 3, 32'h300);
        store(1, 3, 32'h400);
        tick();
        clr();
        expect_viol("s2", 1'b1, 20, 32'h2010);

        // Same-cycle load writeback to idx 7 is seen by the check.
        ld(7, 32'h500);
        store(0, 6, 32'h500);
        tick();
        clr();
        expect_viol("byp", 1'b1, 23, 32'h201c);

        // Store positioned at the tail has no younger loads.
        store(1, 8, 32'h100);
        tick();
        clr();
        check("tail_noviol", 32'(lq_if.viol), 32'd0);

        // Wrap: head moves to 6, then loads land in entries 0 and 1.
        lq_if.retire_cnt = 2'd2; tick();
        lq_if.retire_cnt = 2'd2; tick();
        clr();
        check("wrap_free", 32'(lq_if.free_slots), 32'd6);
        set_alloc(2'b11, 8, 32'h3000);
        #1;
        check("wrap_idx0", 32'(lq_if.alloc_idx[0]), 32'd8);
        check("wrap_idx1", 32'(lq_if.alloc_idx[1]), 32'd9);
        tick();
        clr();
        check("wrap_free2", 32'(lq_if.free_slots), 32'd4);
        ld(8, 32'h600);
        tick();
        clr();
        store(0, 7, 32'h600);
        tick();
        clr();
        expect_viol("wrap", 1'b1, 8, 32'h3000);
        store(0, 7, 32'h300);   // idx 6 is older than the store
        tick();
        clr();
        check("wrap_older", 32'(lq_if.viol), 32'd0);
        store(0, 10, 32'h600);
        tick();
        clr();
        check("wrap_tail", 32'(lq_if.viol), 32'd0);

        // Sub-word addresses in the same word.
        ld(9, 32'h101);
        tick();
        clr();
        store(1, 7, 32'h102);
        tick();
        clr();
`ifdef LQ_WORD_MATCH_EN
        expect_viol("word", 1'b1, 9, 32'h3004);
`else
        expect_viol("word", 1'b0, 0, 0);
`endif

        // Async reset mid-cycle while a violation is showing and loads dispatch.
        store(0, 7, 32'h600);
        tick();
        clr();
        check("pre_rst_viol", 32'(lq_if.viol), 32'd1);
        set_alloc(2'b11, 0, 0);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_free", 32'(lq_if.free_slots), 32'd8);
        expect_viol("arst", 1'b0, 0, 0);
        check("arst_idx1", 32'(lq_if.alloc_idx[1]), 32'd1);
        tick();
        reset_n = 1'b1;
        clr();
        check("arst_free2", 32'(lq_if.free_slots), 32'd8);
        set_alloc(2'b01, 0, 0);
        tick();
        clr();
        check("post_rst_free", 32'(lq_if.free_slots), 32'd7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
